// File: rtl/mem_access_unit.sv
// Data-memory access stage: alignment check, store lane encoding, bus handshake
// with timeout abort, and LL/SC link tracking for a single outstanding access.
module mem_access_unit #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_ll,
   input  logic        req_sc,
   input  logic        ll_clear,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_byte_offset,
   output logic        resp_sc_ok,
   output logic        addr_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);
   localparam int unsigned TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t        state_reg, state_next;
   logic [TW-1:0] tmo_cnt_reg;
   logic          link_reg;
   logic [29:0]   link_addr_reg;
   logic          lat_ll_reg, lat_sc_reg;
   logic [1:0]    lat_offset_reg;
   logic          bus_req_reg, bus_we_reg;
   logic [31:0]   bus_addr_reg, bus_wdata_reg;
   logic [3:0]    bus_wstrb_reg;
   logic [31:0]   resp_rdata_reg;
   logic [1:0]    resp_offset_reg;
   logic          resp_sc_ok_reg, bus_err_reg;

   // Decoded view of the incoming request; LL/SC are forced to word accesses
   logic          is_sc_in, is_ll_in, we_in, misaligned, link_hit, tmo_last;
   logic [1:0]    size_in;
   logic [3:0]    wstrb_in;
   logic [31:0]   wdata_in;
   logic          stall_c, addr_err_c;
   logic          accept, sc_fail, complete, timeout;

   assign is_sc_in = req_sc;
   assign is_ll_in = req_ll & ~req_sc;
   assign size_in  = (req_ll | req_sc) ? 2'b10 : req_size;
   assign we_in    = req_sc | (req_we & ~req_ll);
   assign link_hit = link_reg && (link_addr_reg == req_addr[31:2]);
   assign tmo_last = (tmo_cnt_reg == TW'(BUS_TIMEOUT - 1));

   always_comb begin
      misaligned = 1'b0;
      wstrb_in   = 4'b0000;
      wdata_in   = 32'h0;
      case (size_in)
         2'b00: begin
            misaligned = 1'b0;
            wstrb_in   = 4'b0001 << req_addr[1:0];
            wdata_in   = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = req_addr[0];
            wstrb_in   = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_in   = {2{req_wdata[15:0]}};
         end
         default: begin
            misaligned = |req_addr[1:0];
            wstrb_in   = 4'b1111;
            wdata_in   = req_wdata;
         end
      endcase
      if (!we_in) begin
         wstrb_in = 4'b0000;
         wdata_in = 32'h0;
      end
   end

   always_comb begin
      state_next = state_reg;
      stall_c    = 1'b0;
      addr_err_c = 1'b0;
      accept     = 1'b0;
      sc_fail    = 1'b0;
      complete   = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               if (misaligned) begin
                  addr_err_c = 1'b1;
               end else if (is_sc_in && !link_hit) begin
                  sc_fail    = 1'b1;
                  stall_c    = 1'b1;
                  state_next = DONE;
               end else begin
                  accept     = 1'b1;
                  stall_c    = 1'b1;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            stall_c = 1'b1;
            if (bus_gnt && bus_rvalid) begin
               complete   = 1'b1;
               state_next = DONE;
            end else if (tmo_last) begin
               timeout    = 1'b1;
               state_next = DONE;
            end else if (bus_gnt) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (bus_rvalid) begin
               complete   = 1'b1;
               state_next = DONE;
            end else if (tmo_last) begin
               timeout    = 1'b1;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         tmo_cnt_reg     <= '0;
         link_reg        <= 1'b0;
         link_addr_reg   <= '0;
         lat_ll_reg      <= 1'b0;
         lat_sc_reg      <= 1'b0;
         lat_offset_reg  <= 2'b00;
         bus_req_reg     <= 1'b0;
         bus_we_reg      <= 1'b0;
         bus_addr_reg    <= '0;
         bus_wstrb_reg   <= '0;
         bus_wdata_reg   <= '0;
         resp_rdata_reg  <= '0;
         resp_offset_reg <= 2'b00;
         resp_sc_ok_reg  <= 1'b0;
         bus_err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bus_req_reg <= (state_next == REQ);
         if (accept) begin
            lat_ll_reg     <= is_ll_in;
            lat_sc_reg     <= is_sc_in;
            lat_offset_reg <= req_addr[1:0];
            bus_we_reg     <= we_in;
            bus_addr_reg   <= {req_addr[31:2], 2'b00};
            bus_wstrb_reg  <= wstrb_in;
            bus_wdata_reg  <= wdata_in;
            tmo_cnt_reg    <= '0;
         end else if (state_reg == REQ || state_reg == WAIT) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
         end
         if (sc_fail) begin
            resp_rdata_reg  <= '0;
            resp_offset_reg <= req_addr[1:0];
            resp_sc_ok_reg  <= 1'b0;
            bus_err_reg     <= 1'b0;
         end else if (complete) begin
            resp_rdata_reg  <= bus_we_reg ? 32'h0 : bus_rdata;
            resp_offset_reg <= lat_offset_reg;
            resp_sc_ok_reg  <= lat_sc_reg;
            bus_err_reg     <= 1'b0;
         end else if (timeout) begin
            resp_rdata_reg  <= '0;
            resp_offset_reg <= lat_offset_reg;
            resp_sc_ok_reg  <= 1'b0;
            bus_err_reg     <= 1'b1;
         end
         // Exception-return clear beats a coincident LL completion
         if (ll_clear) begin
            link_reg <= 1'b0;
         end else if (complete && lat_ll_reg) begin
            link_reg      <= 1'b1;
            link_addr_reg <= bus_addr_reg[31:2];
         end else if ((complete && lat_sc_reg) || sc_fail) begin
            link_reg <= 1'b0;
         end
      end
   end

   assign stall            = stall_c & ~rst;
   assign addr_err         = addr_err_c & ~rst;
   assign resp_valid       = (state_reg == DONE);
   assign resp_rdata       = resp_rdata_reg;
   assign resp_byte_offset = resp_offset_reg;
   assign resp_sc_ok       = resp_sc_ok_reg & (state_reg == DONE);
   assign bus_err          = bus_err_reg & (state_reg == DONE);
   assign bus_req          = bus_req_reg;
   assign bus_we           = bus_we_reg;
   assign bus_addr         = bus_addr_reg;
   assign bus_wstrb        = bus_wstrb_reg;
   assign bus_wdata        = bus_wdata_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, LL/SC,
// bus timeout and mid-access reset, with hand-computed expectations.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_ll, req_sc, ll_clear;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, resp_valid, resp_sc_ok, addr_err, bus_err;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_byte_offset;
   logic        bus_req, bus_we, bus_gnt, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   int n_checks = 0;
   int n_pass   = 0;

   // Values captured by the access task
   int          a_stall, a_req, a_done;
   logic        a_we, a_sc_ok, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_wstrb;
   logic [1:0]  a_off;

   mem_access_unit #(.BUS_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ll(req_ll),
      .req_sc(req_sc), .ll_clear(ll_clear),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_byte_offset(resp_byte_offset), .resp_sc_ok(resp_sc_ok),
      .addr_err(addr_err), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic drop_req();
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_addr = '0;
      req_wdata = '0; req_ll = 1'b0; req_sc = 1'b0;
   endtask

   // One access with a bus that grants immediately; data/ack arrives one cycle
   // after the grant, or in the grant cycle when same=1.
   task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ll, input logic sc,
                         input logic [31:0] rd, input bit same);
      logic gnt_prev;
      gnt_prev = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr;
      req_wdata = wdata; req_ll = ll; req_sc = sc; ll_clear = 1'b0;
      a_stall = 0; a_req = 0; a_done = -1;
      a_we = 1'b0; a_addr = '0; a_wstrb = '0; a_wdata = '0;
      a_rdata = '0; a_off = '0; a_sc_ok = 1'b0; a_err = 1'b0;
      for (int i = 0; i < 40 && a_done < 0; i++) begin
         #1;
         if (resp_valid) begin
            a_done  = i;
            a_rdata = resp_rdata;
            a_off   = resp_byte_offset;
            a_sc_ok = resp_sc_ok;
            a_err   = bus_err;
            check("stall_in_done", {31'h0, stall}, 32'h0);
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
         end else begin
            if (stall) a_stall++;
            if (bus_req) begin
               a_req++;
               a_we = bus_we; a_addr = bus_addr; a_wstrb = bus_wstrb; a_wdata = bus_wdata;
            end
            bus_gnt    = bus_req;
            bus_rvalid = same ? bus_req : gnt_prev;
            bus_rdata  = rd;
            gnt_prev   = bus_gnt;
            @(negedge clk);
         end
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (a_done < 0) check("resp_wait_expired", 32'h0, 32'h1);
      $display("txn addr=0x%08h we=%b size=%0d ll=%b sc=%b done_at=%0d stall=%0d req=%0d rdata=0x%08h off=%0d sc_ok=%b err=%b",
               addr, we, size, ll, sc, a_done, a_stall, a_req, a_rdata, a_off, a_sc_ok, a_err);
      @(negedge clk);
      drop_req();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, done;
      rst = 1'b1; ll_clear = 1'b0; drop_req();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);

      // lb at 0x1003
      access(1'b0, 2'b00, 32'h0000_1003, 32'h0, 1'b0, 1'b0, 32'hAABB_CCDD, 1'b0);
      check("lb_stall_cycles", 32'(a_stall), 32'd3);
      check("lb_resp_at", 32'(a_done), 32'd3);
      check("lb_req_cycles", 32'(a_req), 32'd1);
      check("lb_bus_addr", a_addr, 32'h0000_1000);
      check("lb_wstrb", {28'h0, a_wstrb}, 32'h0);
      check("lb_rdata", a_rdata, 32'hAABB_CCDD);
      check("lb_offset", {30'h0, a_off}, 32'd3);

      // sh 0x1234 at 0x2002 with grant and ack in the same cycle
      access(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b1);
      check("sh_bus_addr", a_addr, 32'h0000_2000);
      check("sh_wstrb", {28'h0, a_wstrb}, 32'hC);
      check("sh_wdata", a_wdata, 32'h1234_1234);
      check("sh_we", {31'h0, a_we}, 32'h1);
      check("sh_resp_at", 32'(a_done), 32'd2);
      check("sh_rdata", a_rdata, 32'h0);

      // sb 0xAB at 0x5001
      access(1'b1, 2'b00, 32'h0000_5001, 32'h0000_00AB, 1'b0, 1'b0, 32'h0, 1'b0);
      check("sb_wstrb", {28'h0, a_wstrb}, 32'h2);
      check("sb_wdata", a_wdata, 32'hABAB_ABAB);

      // lw at 0x3001: misaligned
      @(negedge clk);
      req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_3001;
      #1;
      check("lw_mis_addr_err", {31'h0, addr_err}, 32'h1);
      check("lw_mis_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      drop_req();
      #1;
      check("lw_mis_bus_req", {31'h0, bus_req}, 32'h0);
      check("lw_mis_err_gone", {31'h0, addr_err}, 32'h0);
      $display("txn addr=0x00003001 misaligned lw");

      // ll / sc / sc again
      access(1'b0, 2'b10, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 32'h0000_0011, 1'b0);
      check("ll_rdata", a_rdata, 32'h0000_0011);
      access(1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0, 1'b0);
      check("sc1_ok", {31'h0, a_sc_ok}, 32'h1);
      check("sc1_wstrb", {28'h0, a_wstrb}, 32'hF);
      check("sc1_wdata", a_wdata, 32'hCAFE_F00D);
      check("sc1_req", 32'(a_req), 32'd1);
      access(1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0, 1'b0);
      check("sc2_ok", {31'h0, a_sc_ok}, 32'h0);
      check("sc2_req", 32'(a_req), 32'd0);
      check("sc2_resp_at", 32'(a_done), 32'd1);

      // ll, ll_clear, sc
      access(1'b0, 2'b10, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      ll_clear = 1'b1;
      access(1'b1, 2'b10, 32'h0000_4000, 32'h1, 1'b0, 1'b1, 32'h0, 1'b0);
      check("sc_after_clear_ok", {31'h0, a_sc_ok}, 32'h0);
      check("sc_after_clear_req", 32'(a_req), 32'd0);

      // Bus never grants: timeout abort
      @(negedge clk);
      req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_6000;
      cnt = 0; done = -1;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (resp_valid) begin done = i; break; end
         if (stall) cnt++;
         @(negedge clk);
      end
      check("tmo_resp_at", 32'(done), 32'd256);
      check("tmo_stall_cycles", 32'(cnt), 32'd256);
      check("tmo_bus_err", {31'h0, bus_err}, 32'h1);
      check("tmo_rdata", resp_rdata, 32'h0);
      $display("txn addr=0x00006000 timeout done_at=%0d", done);
      @(negedge clk);
      drop_req();
      bus_rvalid = 1'b1; bus_rdata = 32'h0000_DEAD;
      #1;
      check("tmo_err_cleared", {31'h0, bus_err}, 32'h0);
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      check("stray_rvalid_resp", {31'h0, resp_valid}, 32'h0);
      check("stray_rvalid_rdata", resp_rdata, 32'h0);

      // Reset while in WAIT with a live link
      access(1'b0, 2'b10, 32'h0000_8000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_7000;
      @(negedge clk);
      #1;
      check("rstw_req_phase", {31'h0, bus_req}, 32'h1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      check("rstw_wait_stall", {31'h0, stall}, 32'h1);
      rst = 1'b1; drop_req();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstw_stall", {31'h0, stall}, 32'h0);
      check("rstw_bus_req", {31'h0, bus_req}, 32'h0);
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      check("rstw_late_rvalid", {31'h0, resp_valid}, 32'h0);
      $display("txn addr=0x00007000 reset in WAIT");
      access(1'b0, 2'b10, 32'h0000_7000, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
      check("post_rst_lw_rdata", a_rdata, 32'h1234_5678);
      check("post_rst_lw_at", 32'(a_done), 32'd3);
      access(1'b1, 2'b10, 32'h0000_8000, 32'h5, 1'b0, 1'b1, 32'h0, 1'b0);
      check("post_rst_sc_ok", {31'h0, a_sc_ok}, 32'h0);
      check("post_rst_sc_req", 32'(a_req), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage between the MEM pipeline stage and the word-wide data bus.
- Takes one load/store request, checks alignment, and generates the bus address, write strobes and replicated write data.
- Runs the bus handshake and holds LL/SC link state.
- Returns the raw read word plus the byte offset to the downstream load-extension logic, and holds the pipeline stalled while an access is in flight.

Parameters:
- BUS_TIMEOUT, 255: cycles spent in REQ+WAIT with no completion before the access is aborted with bus_err.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage presents an access; held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ll  in  1  load-linked (word)
- req_sc  in  1  store-conditional (word)
- ll_clear  in  1  clears the link bit (exception return)
- stall  out  1  freeze pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  raw aligned word read from the bus
- resp_byte_offset  out  2  req_addr[1:0] of the completed access
- resp_sc_ok  out  1  SC succeeded (valid with resp_valid)
- addr_err  out  1  one-cycle misalignment pulse
- bus_err  out  1  timeout abort (valid with resp_valid)
- bus_req  out  1  bus request, registered
- bus_we  out  1  bus write, registered
- bus_addr  out  32  {req_addr[31:2],2'b00}, registered
- bus_wstrb  out  4  byte strobes, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_gnt  in  1  address phase accepted
- bus_rvalid  in  1  data or write acknowledge
- bus_rdata  in  32  read data

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, link bit and link address cleared, timeout counter cleared.
  - All outputs 0, including stall.
  - Applies even mid-access; the outstanding bus transaction is abandoned.
  - A late bus_gnt or bus_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1:
  - Misaligned (half with addr[0]=1; word/LL/SC with addr[1:0]!=0): addr_err=1 for that cycle, stall=0, no bus activity, stay in IDLE.
  - SC with link bit clear or link address != addr[31:2]: go to DONE with no bus access, resp_sc_ok=0; stall=1 during the IDLE cycle.
  - Otherwise: latch the request and go to REQ. stall=1, combinationally, in this IDLE cycle.
- REQ:
  - bus_req=1; stall=1.
  - bus_gnt=1 moves to WAIT and drops bus_req the next cycle.
  - If bus_gnt and bus_rvalid arrive in the same cycle, go straight to DONE.
- WAIT:
  - stall=1.
  - bus_rvalid=1 captures bus_rdata (loads; stores capture 0) and moves to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; stall=0 so the pipeline advances.
  - req_valid is ignored in this cycle (it is still the old instruction).
  - Always returns to IDLE.
  - resp_rdata and resp_byte_offset remain stable until the next DONE.
- Minimum latency with bus_gnt in the first REQ cycle and bus_rvalid one cycle later: request at T0, bus_req at T1, resp_valid at T3, stall high T0–T2.
- Store encoding:
  - byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111.
  - Loads: wstrb = 0000.
- LL/SC:
  - A completed LL sets the link bit and link address = addr[31:2].
  - A successful SC completes as a word store, resp_sc_ok=1, and clears the link bit.
  - A failed SC also clears the link bit.
  - ll_clear=1 clears the link bit on any cycle. When ll_clear and an LL completion coincide, clear wins.
- Timeout:
  - Counter increments each cycle in REQ or WAIT and resets on entering REQ.
  - On reaching BUS_TIMEOUT: go to DONE with bus_err=1, resp_rdata=0, resp_sc_ok=0, and no link update.
- req_ll and req_sc both set: treated as SC.

Test Plan:
- lb at 0x1003, bus_gnt immediate, bus_rvalid next cycle with 0xAABBCCDD: stall high 3 cycles, then resp_valid with resp_rdata=0xAABBCCDD and resp_byte_offset=3.
- sh 0x1234 at 0x2002: bus_addr=0x2000, bus_wstrb=1100, bus_wdata=0x12341234, bus_we=1, resp_valid after ack.
- lw at 0x3001: addr_err pulse for one cycle, stall=0, bus_req never asserted.
- ll 0x4000, then sc 0x4000 → resp_sc_ok=1 with wstrb=1111. A second sc 0x4000 → resp_sc_ok=0 with no bus_req. ll, then ll_clear, then sc → fails.
- bus_gnt withheld for BUS_TIMEOUT cycles: resp_valid with bus_err=1 and resp_rdata=0. A later stray bus_rvalid is ignored.
- rst asserted while in WAIT: next cycle state IDLE, stall=0, bus_req=0, link bit 0. A subsequent lw completes normally.
